// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Width defaults and the 3-bit fetch state type live here so other stages can reuse them.
package if_fetch_unit_pkg;

    localparam int IM_ADDR_BIT  = 10;
    localparam int FETCH_ST_BIT = 3;

    typedef enum logic [FETCH_ST_BIT-1:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4,
        ST_HALT  = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack read to instruction
// memory and feeds {inst, pc_4} plus enable/clear controls to the IF/ID register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int IM_ADDR_W = IM_ADDR_BIT,
    parameter int RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 redirect_en,
    input  logic [IM_ADDR_W-1:0] redirect_pc,
    input  logic                 halt,
    output logic                 imem_req,
    output logic [IM_ADDR_W-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          inst,
    output logic [IM_ADDR_W-1:0] pc_4,
    output logic                 fetch_valid,
    output logic                 if_id_en,
    output logic                 if_id_clr,
    output logic                 halted
);

    fetch_state_e         state_q, state_d;
    logic [IM_ADDR_W-1:0] pc_q, pc_d;
    logic [IM_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]          buf_q, buf_d;
    logic                 halt_pend_q, halt_pend_d;

    logic [IM_ADDR_W-1:0] pc_inc;
    logic                 halting;
    logic                 bubble;

    assign pc_inc  = pc_q + IM_ADDR_W'(1);
    assign halting = halt | halt_pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= IM_ADDR_W'(RESET_PC);
            addr_q      <= '0;
            buf_q       <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            buf_q       <= buf_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        buf_d       = buf_q;
        halt_pend_d = halt_pend_q | halt;
        case (state_q)
            ST_IDLE: begin
                if (halting) begin
                    state_d = ST_HALT;
                end else begin
                    if (redirect_en) pc_d = redirect_pc;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH, ST_WAIT: begin
                if (state_q == ST_FETCH) addr_d = pc_q;
                // A request that is still open when flushed must be drained before reuse.
                if (halting) begin
                    state_d = imem_ack ? ST_HALT : ST_DRAIN;
                end else if (redirect_en) begin
                    pc_d    = redirect_pc;
                    state_d = imem_ack ? ST_FETCH : ST_DRAIN;
                end else if (imem_ack) begin
                    if (stall) begin
                        buf_d   = imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (redirect_en && !halting) pc_d = redirect_pc;
                if (imem_ack) state_d = halting ? ST_HALT : ST_FETCH;
            end
            ST_HOLD: begin
                if (halting) begin
                    state_d = ST_HALT;
                end else if (redirect_en) begin
                    pc_d    = redirect_pc;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = addr_q;
        inst        = '0;
        pc_4        = '0;
        fetch_valid = 1'b0;
        halted      = 1'b0;
        if_id_en    = !stall;
        case (state_q)
            ST_FETCH, ST_WAIT: begin
                imem_req  = 1'b1;
                imem_addr = (state_q == ST_FETCH) ? pc_q : addr_q;
                // Zero-cycle pass-through of the returning word.
                if (imem_ack && !halting && !redirect_en) begin
                    fetch_valid = 1'b1;
                    inst        = imem_rdata;
                    pc_4        = pc_inc;
                end
            end
            ST_DRAIN: imem_req = 1'b1;
            ST_HOLD: begin
                if (!halting && !redirect_en) begin
                    fetch_valid = 1'b1;
                    inst        = buf_q;
                    pc_4        = pc_inc;
                end
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
        // IDLE has nothing in IF/ID yet, so it does not count as an empty-fetch bubble.
        bubble    = !fetch_valid && !stall && (state_q != ST_IDLE);
        if_id_clr = !(redirect_en | halt | halt_pend_q | bubble);
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, reset sequences, then randomized traffic
// against a transaction-level model of the fetch stage and a random-latency memory.
module tb_if_fetch_unit;

    localparam int AW = 10;

    typedef struct packed {
        logic          req;
        logic [AW-1:0] addr;
        logic          fv;
        logic [31:0]   inst;
        logic [AW-1:0] pc4;
        logic          en;
        logic          clr;
        logic          halted;
    } obs_t;

    typedef struct {
        logic          stall;
        logic          redir;
        logic [AW-1:0] rpc;
        logic          halt;
        logic          ack;
        logic [31:0]   rdata;
        obs_t          exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, redirect_en, halt, imem_ack;
    logic [AW-1:0] redirect_pc;
    logic [31:0]   imem_rdata;
    logic          imem_req, fetch_valid, if_id_en, if_id_clr, halted;
    logic [AW-1:0] imem_addr, pc_4;
    logic [31:0]   inst;

    int n_vec = 0;
    int n_err = 0;

    // Model of the fetch stage in terms of "what is in flight" rather than named states.
    logic          m_started, m_stopped, m_hp, m_busy, m_discard, m_have_buf;
    logic [AW-1:0] m_pc, m_out_addr;
    logic [31:0]   m_buf;
    int            mem_cnt, mem_lat;

    if_fetch_unit #(.IM_ADDR_W(AW), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .pc_4(pc_4),
        .fetch_valid(fetch_valid), .if_id_en(if_id_en), .if_id_clr(if_id_clr), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic obs_t o(input logic req, input logic [AW-1:0] addr, input logic fv,
                               input logic [31:0] ins, input logic [AW-1:0] pc4,
                               input logic en, input logic clr, input logic hl);
        obs_t x;
        x = '{req: req, addr: addr, fv: fv, inst: ins, pc4: pc4, en: en, clr: clr, halted: hl};
        return x;
    endfunction

    function automatic vec_t v(input logic s, input logic r, input logic [AW-1:0] rp,
                               input logic h, input logic a, input logic [31:0] rd, input obs_t e);
        vec_t x;
        x.stall = s; x.redir = r; x.rpc = rp; x.halt = h; x.ack = a; x.rdata = rd; x.exp = e;
        return x;
    endfunction

    function automatic string fmt(input obs_t x);
        return $sformatf("req=%b addr=%0d fv=%b inst=%h pc4=%0d en=%b clr=%b halted=%b",
                         x.req, x.addr, x.fv, x.inst, x.pc4, x.en, x.clr, x.halted);
    endfunction

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {{(32-AW){1'b0}}, a} ^ 32'hA5A5A5A5;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = {imem_req, imem_addr, fetch_valid, inst, pc_4, if_id_en, if_id_clr, halted};
        if (!exp.req) exp.addr = act.addr;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %s, want %s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [AW-1:0] rp,
                         input logic h, input logic a, input logic [31:0] rd);
        stall = s; redirect_en = r; redirect_pc = rp; halt = h; imem_ack = a; imem_rdata = rd;
    endtask

    task automatic step(input string name, input vec_t t);
        drive(t.stall, t.redir, t.rpc, t.halt, t.ack, t.rdata);
        #1;
        check(name, t.exp);
        $display("%s: stall=%b redir=%b halt=%b ack=%b -> %s", name, t.stall, t.redir, t.halt,
                 t.ack, fmt(t.exp));
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_started = 0; m_stopped = 0; m_hp = 0; m_busy = 0; m_discard = 0; m_have_buf = 0;
        m_pc = '0; m_out_addr = '0; m_buf = '0;
        mem_cnt = 0; mem_lat = 0;
    endtask

    function automatic logic model_req();
        return m_started && !m_stopped && !m_have_buf;
    endfunction

    function automatic logic [AW-1:0] model_addr();
        return m_busy ? m_out_addr : m_pc;
    endfunction

    task automatic model_step(input logic s, input logic r, input logic [AW-1:0] rp,
                              input logic h, input logic a, input logic [31:0] rd, output obs_t e);
        logic fv, hp0, stopped0, idle;
        logic [31:0] ins;
        logic [AW-1:0] p4, ad;
        fv = 0; ins = '0; p4 = '0; idle = 0; hp0 = m_hp; stopped0 = m_stopped;
        ad = model_addr();
        e.req = model_req();
        e.addr = ad;
        if (m_stopped) begin
            // nothing moves once fetch has stopped
        end else if (!m_started) begin
            idle = 1; m_started = 1;
            if (h) begin m_hp = 1; m_stopped = 1; end
            else if (r) m_pc = rp;
        end else if (m_have_buf) begin
            if (h) begin m_hp = 1; m_stopped = 1; m_have_buf = 0; end
            else if (r) begin m_pc = rp; m_have_buf = 0; end
            else begin
                fv = 1; ins = m_buf; p4 = AW'(m_pc + 1);
                if (!s) begin m_pc = AW'(m_pc + 1); m_have_buf = 0; end
            end
        end else if (m_discard) begin
            if (h) m_hp = 1;
            if (r && !(h || hp0)) m_pc = rp;
            if (a) begin m_busy = 0; m_discard = 0; if (m_hp) m_stopped = 1; end
        end else begin
            if (h || hp0) begin
                m_hp = 1;
                if (a) begin m_stopped = 1; m_busy = 0; end
                else begin m_out_addr = ad; m_busy = 1; m_discard = 1; end
            end else if (r) begin
                m_pc = rp;
                if (a) m_busy = 0;
                else begin m_out_addr = ad; m_busy = 1; m_discard = 1; end
            end else if (a) begin
                fv = 1; ins = rd; p4 = AW'(m_pc + 1); m_busy = 0;
                if (s) begin m_have_buf = 1; m_buf = rd; end
                else m_pc = AW'(m_pc + 1);
            end else begin
                m_out_addr = ad; m_busy = 1;
            end
        end
        e.fv = fv; e.inst = ins; e.pc4 = p4; e.en = !s; e.halted = stopped0;
        e.clr = idle ? !(r | h) : !(r | h | hp0 | (!fv & !s));
    endtask

    // Asserts rst_n immediately, checks the asynchronous reset values, releases on a negedge.
    task automatic do_reset(input string name);
        rst_n = 1'b0;
        drive(0, 0, '0, 0, 0, '0);
        #1;
        check(name, o(0, 0, 0, 0, 0, 1, 1, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    localparam logic [31:0] D0 = 32'h1111_0000, D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'h3333_0002, D3 = 32'h4444_03FF;

    initial begin
        vec_t tbl[18];
        obs_t e;
        logic s, r, h, a;
        logic [AW-1:0] rp, ad;
        logic [31:0] rd;

        rst_n = 1'b1;
        drive(0, 0, '0, 0, 0, '0);
        model_reset();

        //           stall redir rpc  halt ack rdata         req addr fv inst pc4 en clr halted
        tbl[0]  = v(0, 0, 0,    0, 0, 0,            o(0, 0,    0, 0,  0, 1, 1, 0));
        tbl[1]  = v(0, 0, 0,    0, 1, D0,           o(1, 0,    1, D0, 1, 1, 1, 0));
        tbl[2]  = v(0, 0, 0,    0, 0, 0,            o(1, 1,    0, 0,  0, 1, 0, 0));
        tbl[3]  = v(0, 0, 0,    0, 0, 0,            o(1, 1,    0, 0,  0, 1, 0, 0));
        tbl[4]  = v(0, 0, 0,    0, 1, D1,           o(1, 1,    1, D1, 2, 1, 1, 0));
        tbl[5]  = v(1, 0, 0,    0, 1, D2,           o(1, 2,    1, D2, 3, 0, 1, 0));
        tbl[6]  = v(1, 0, 0,    0, 0, 0,            o(0, 0,    1, D2, 3, 0, 1, 0));
        tbl[7]  = v(0, 0, 0,    0, 0, 0,            o(0, 0,    1, D2, 3, 1, 1, 0));
        tbl[8]  = v(1, 1, 1023, 0, 0, 0,            o(1, 3,    0, 0,  0, 0, 0, 0));
        tbl[9]  = v(0, 0, 0,    0, 0, 0,            o(1, 3,    0, 0,  0, 1, 0, 0));
        tbl[10] = v(0, 0, 0,    0, 1, 32'hDEADBEEF, o(1, 3,    0, 0,  0, 1, 0, 0));
        tbl[11] = v(0, 0, 0,    0, 1, D3,           o(1, 1023, 1, D3, 0, 1, 1, 0));
        tbl[12] = v(0, 0, 0,    0, 0, 0,            o(1, 0,    0, 0,  0, 1, 0, 0));
        tbl[13] = v(0, 0, 0,    1, 0, 0,            o(1, 0,    0, 0,  0, 1, 0, 0));
        tbl[14] = v(0, 0, 0,    0, 0, 0,            o(1, 0,    0, 0,  0, 1, 0, 0));
        tbl[15] = v(0, 0, 0,    0, 1, 32'hBADC0DE0, o(1, 0,    0, 0,  0, 1, 0, 0));
        tbl[16] = v(0, 0, 0,    0, 0, 0,            o(0, 0,    0, 0,  0, 1, 0, 1));
        tbl[17] = v(1, 1, 5,    0, 0, 0,            o(0, 0,    0, 0,  0, 0, 0, 1));

        #3;
        do_reset("reset_por");
        for (int i = 0; i < 18; i++) step($sformatf("vec%0d", i), tbl[i]);

        // Reset while halted, then asynchronous reset in the middle of a wait state.
        do_reset("reset_from_halt");
        step("seq_idle",  v(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 1, 1, 0)));
        step("seq_fetch", v(0, 0, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 1, 0, 0)));
        step("seq_wait",  v(0, 0, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 1, 0, 0)));
        #2;
        do_reset("reset_mid_wait");
        step("seq_idle2", v(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 1, 1, 0)));
        step("seq_zero_wait", v(0, 0, 0, 0, 1, mem_word(0), o(1, 0, 1, mem_word(0), 1, 1, 1, 0)));
        step("seq_zero_wait2", v(0, 0, 0, 0, 1, mem_word(1), o(1, 1, 1, mem_word(1), 2, 1, 1, 0)));

        // Randomized traffic against the model with a 0..2 wait-state memory.
        do_reset("reset_rand");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 600 == 599) do_reset($sformatf("reset_rand%0d", cyc));
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 11) == 0);
            rp = ($urandom_range(0, 3) == 0) ? AW'(1023 - $urandom_range(0, 1))
                                             : AW'($urandom_range(0, 1023));
            h  = ($urandom_range(0, 249) == 0);
            ad = model_addr();
            a  = model_req() && (mem_cnt >= mem_lat);
            rd = a ? mem_word(ad) : $urandom();
            drive(s, r, rp, h, a, rd);
            #1;
            model_step(s, r, rp, h, a, rd, e);
            check($sformatf("rand%0d", cyc), e);
            if (e.req) begin
                if (a) begin mem_cnt = 0; mem_lat = $urandom_range(0, 2); end
                else mem_cnt++;
            end else begin
                mem_cnt = 0;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
